// File: rtl/surf_wb_intercon_if.sv
// surf_wb_intercon_if -- WISHBONE classic bus bundle used by the SURF
// register interconnect.
//
// Parameters:
//   AW     address width (22 for masters, 12 or 17 for slaves)
// Signals (named from the bus master's point of view):
//   cyc, stb, we, adr, dat_w, sel   master -> slave
//   dat_r, ack, err, rty            slave  -> master
// Modports:
//   master  the side that issues cycles
//   slave   the side that answers cycles
interface surf_wb_intercon_if #(
  parameter int unsigned AW = 22
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [31:0]   dat_w;
  logic [3:0]    sel;
  logic [31:0]   dat_r;
  logic          ack;
  logic          err;
  logic          rty;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err, rty
  );
endinterface

// File: rtl/surf_wb_intercon.sv
// surf_wb_intercon -- two-master, five-slave WISHBONE interconnect for the
// SURF 22-bit register space.
//
// Round-robin arbitration between the board-manager master (bm) and the
// TURF command master (tc); the winner's address is decoded onto one of the
// ID/control, notch, AGC, beam or RFdc slaves. Unmapped addresses return err
// with UNMAPPED_DATA one cycle after stb.
//
// Optional feature macro: WB_TIMEOUT_EN
//   defined   -> bus watchdog active (TIMEOUT parameter, timeout_o pulse)
//   undefined -> no watchdog, timeout_o tied low
//
// Ports:
//   wb_clk_i      register clock
//   wb_rst_ni     asynchronous active-low reset
//   bm, tc        master-facing buses (slave modport)
//   surf_id_ctrl, notch, agc, beam (12-bit adr), rfdc (17-bit adr)
//                 slave-facing buses (master modport)
//   grant_o       one-hot owner, [0]=bm, [1]=tc
//   timeout_o     one-cycle pulse on watchdog expiry
module surf_wb_intercon #(
`ifdef WB_TIMEOUT_EN
  parameter int unsigned TIMEOUT       = 1024,
`endif
  parameter logic [31:0] UNMAPPED_DATA = 32'hBADADD00
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  surf_wb_intercon_if.slave  bm,
  surf_wb_intercon_if.slave  tc,
  surf_wb_intercon_if.master surf_id_ctrl,
  surf_wb_intercon_if.master notch,
  surf_wb_intercon_if.master agc,
  surf_wb_intercon_if.master beam,
  surf_wb_intercon_if.master rfdc,
  output logic [1:0]         grant_o,
  output logic               timeout_o
);

  typedef enum logic [1:0] {IDLE, OWN, HOLDOFF} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;  // 0 = bm, 1 = tc
  logic        last_q, last_d;    // previous owner, for round-robin ties
  logic        active;

  logic        own_cyc, own_stb, own_we;
  logic [21:0] own_adr;
  logic [31:0] own_dat;
  logic [3:0]  own_sel;

  logic [4:0]  hit;               // {rfdc, beam, agc, notch, id}
  logic        unmapped;
  logic        unm_err_q;
  logic        wd_fire;
  logic        drive;

  logic        rsp_ack, rsp_err, rsp_rty;
  logic [31:0] rsp_dat;
  logic        m_ack, m_err, m_rty;
  logic [31:0] m_dat;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      unm_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      unm_err_q <= active && own_cyc && own_stb && unmapped && !unm_err_q;
    end
  end

  // HOLDOFF arbitrates exactly like IDLE, so a waiting master is granted
  // straight after the single dead cycle instead of passing through IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      OWN: begin
        if (!own_cyc) begin
          state_d = HOLDOFF;
          last_d  = owner_q;
        end
      end
      default: begin
        if (bm.cyc || tc.cyc) begin
          state_d = OWN;
          owner_d = (bm.cyc && tc.cyc) ? ~last_q : tc.cyc;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign active  = (state_q == OWN);
  assign grant_o = active ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  assign own_cyc = owner_q ? tc.cyc   : bm.cyc;
  assign own_stb = owner_q ? tc.stb   : bm.stb;
  assign own_we  = owner_q ? tc.we    : bm.we;
  assign own_adr = owner_q ? tc.adr   : bm.adr;
  assign own_dat = owner_q ? tc.dat_w : bm.dat_w;
  assign own_sel = owner_q ? tc.sel   : bm.sel;

  always_comb begin
    hit      = '0;
    unmapped = 1'b0;
    if (active) begin
      if (own_adr[21]) begin
        hit[4] = 1'b1;
      end else if (own_adr[20:14] == '0) begin
        case (own_adr[13:12])
          2'd0:    hit[0] = 1'b1;
          2'd1:    hit[1] = 1'b1;
          2'd2:    hit[2] = 1'b1;
          default: hit[3] = 1'b1;
        endcase
      end else begin
        unmapped = 1'b1;
      end
    end
  end

  // Watchdog expiry abandons the cycle towards the slave in the same cycle.
  assign drive = active && own_cyc && !wd_fire;

  assign surf_id_ctrl.cyc   = drive && hit[0];
  assign surf_id_ctrl.stb   = drive && hit[0] && own_stb;
  assign surf_id_ctrl.we    = hit[0] && own_we;
  assign surf_id_ctrl.adr   = hit[0] ? own_adr[11:0] : '0;
  assign surf_id_ctrl.dat_w = hit[0] ? own_dat : '0;
  assign surf_id_ctrl.sel   = hit[0] ? own_sel : '0;

  assign notch.cyc   = drive && hit[1];
  assign notch.stb   = drive && hit[1] && own_stb;
  assign notch.we    = hit[1] && own_we;
  assign notch.adr   = hit[1] ? own_adr[11:0] : '0;
  assign notch.dat_w = hit[1] ? own_dat : '0;
  assign notch.sel   = hit[1] ? own_sel : '0;

  assign agc.cyc   = drive && hit[2];
  assign agc.stb   = drive && hit[2] && own_stb;
  assign agc.we    = hit[2] && own_we;
  assign agc.adr   = hit[2] ? own_adr[11:0] : '0;
  assign agc.dat_w = hit[2] ? own_dat : '0;
  assign agc.sel   = hit[2] ? own_sel : '0;

  assign beam.cyc   = drive && hit[3];
  assign beam.stb   = drive && hit[3] && own_stb;
  assign beam.we    = hit[3] && own_we;
  assign beam.adr   = hit[3] ? own_adr[11:0] : '0;
  assign beam.dat_w = hit[3] ? own_dat : '0;
  assign beam.sel   = hit[3] ? own_sel : '0;

  assign rfdc.cyc   = drive && hit[4];
  assign rfdc.stb   = drive && hit[4] && own_stb;
  assign rfdc.we    = hit[4] && own_we;
  assign rfdc.adr   = hit[4] ? own_adr[16:0] : '0;
  assign rfdc.dat_w = hit[4] ? own_dat : '0;
  assign rfdc.sel   = hit[4] ? own_sel : '0;

  assign rsp_ack = |(hit & {rfdc.ack, beam.ack, agc.ack, notch.ack, surf_id_ctrl.ack});
  assign rsp_err = |(hit & {rfdc.err, beam.err, agc.err, notch.err, surf_id_ctrl.err});
  assign rsp_rty = |(hit & {rfdc.rty, beam.rty, agc.rty, notch.rty, surf_id_ctrl.rty});
  assign rsp_dat = ({32{hit[0]}} & surf_id_ctrl.dat_r) | ({32{hit[1]}} & notch.dat_r)
                 | ({32{hit[2]}} & agc.dat_r)          | ({32{hit[3]}} & beam.dat_r)
                 | ({32{hit[4]}} & rfdc.dat_r);

`ifdef WB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [15:0] wd_cnt;
  logic        wd_run;

  assign wd_run  = active && own_cyc && own_stb;
  assign wd_fire = wd_run && (wd_cnt == WD_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wd_cnt <= '0;
    end else if (!wd_run || wd_fire || rsp_ack || rsp_err || rsp_rty || unm_err_q) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign timeout_o = wd_fire;
`else
  assign wd_fire   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // A coincident slave ack/rty is discarded when the watchdog fires.
  assign m_ack = rsp_ack && !wd_fire;
  assign m_rty = rsp_rty && !wd_fire;
  assign m_err = rsp_err || wd_fire || (active && unm_err_q);
  assign m_dat = (active && unm_err_q) ? UNMAPPED_DATA : rsp_dat;

  assign bm.ack   = !owner_q && m_ack;
  assign bm.err   = !owner_q && m_err;
  assign bm.rty   = !owner_q && m_rty;
  assign bm.dat_r = owner_q ? '0 : m_dat;

  assign tc.ack   = owner_q && m_ack;
  assign tc.err   = owner_q && m_err;
  assign tc.rty   = owner_q && m_rty;
  assign tc.dat_r = owner_q ? m_dat : '0;

endmodule
